// File: rtl/l2c_spsram_pkg.sv
// Shared definitions for the L2C single-port SRAM access controllers.
package l2c_spsram_pkg;

  localparam int ADDR_WIDTH = 7;
  localparam int DATA_WIDTH = 104;

  typedef enum logic [1:0] {
    ST_RST  = 2'b00,
    ST_INIT = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/ct_spsram_128x104_ctrl_if.sv
// Requester-side bus of the SRAM controller: two request ports and the read return.
interface ct_spsram_128x104_ctrl_if #(
  parameter int ADDR_WIDTH = l2c_spsram_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = l2c_spsram_pkg::DATA_WIDTH
);
  import l2c_spsram_pkg::*;

  logic                  p0_req_vld;
  logic                  p0_req_wr;
  logic [ADDR_WIDTH-1:0] p0_req_addr;
  logic [DATA_WIDTH-1:0] p0_req_wdata;
  logic [DATA_WIDTH-1:0] p0_req_wmask;
  logic                  p0_req_rdy;

  logic                  p1_req_vld;
  logic                  p1_req_wr;
  logic [ADDR_WIDTH-1:0] p1_req_addr;
  logic [DATA_WIDTH-1:0] p1_req_wdata;
  logic [DATA_WIDTH-1:0] p1_req_wmask;
  logic                  p1_req_rdy;

  logic                  rdata_vld;
  logic                  rdata_src;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output p0_req_vld, p0_req_wr, p0_req_addr, p0_req_wdata, p0_req_wmask,
    input  p0_req_rdy,
    output p1_req_vld, p1_req_wr, p1_req_addr, p1_req_wdata, p1_req_wmask,
    input  p1_req_rdy,
    input  rdata_vld, rdata_src, rdata
  );

  modport slave (
    input  p0_req_vld, p0_req_wr, p0_req_addr, p0_req_wdata, p0_req_wmask,
    output p0_req_rdy,
    input  p1_req_vld, p1_req_wr, p1_req_addr, p1_req_wdata, p1_req_wmask,
    output p1_req_rdy,
    output rdata_vld, rdata_src, rdata
  );

endinterface

// File: rtl/ct_spsram_128x104_arb.sv
// Two-port fixed-priority arbiter: port 0 normally wins, but port 1 is
// guaranteed one grant after STARVE_MAX consecutive losses.
module ct_spsram_128x104_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_vld0,
  input  logic i_vld1,
  output logic o_grant0,
  output logic o_grant1
);

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  logic [3:0] r_starve_cnt;
  logic       w_p1_turn;

  // Grant decision is purely combinational so the winner drives the macro the same cycle.
  always_comb begin
    w_p1_turn = (r_starve_cnt == LP_STARVE_MAX);
    o_grant1  = i_en & i_vld1 & (~i_vld0 | w_p1_turn);
    o_grant0  = i_en & i_vld0 & ~o_grant1;
  end

  // Count consecutive port-1 losses; any port-1 grant or port-1 idle cycle clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 4'd0;
    end else if (!i_en || o_grant1 || !i_vld1) begin
      r_starve_cnt <= 4'd0;
    end else if (o_grant0 && !w_p1_turn) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/ct_spsram_128x104_ctrl.sv
// Access controller for one 128x104 single-port SRAM macro: init sweep after
// reset, then two-port arbitration with a one-cycle tagged read return.
module ct_spsram_128x104_ctrl #(
  parameter int                                  ADDR_WIDTH = l2c_spsram_pkg::ADDR_WIDTH,
  parameter int                                  DATA_WIDTH = l2c_spsram_pkg::DATA_WIDTH,
  parameter int                                  STARVE_MAX = 4,
  parameter logic [l2c_spsram_pkg::DATA_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  ct_spsram_128x104_ctrl_if.slave bus,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  import l2c_spsram_pkg::*;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_init_cnt;

  logic                  w_run;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_gnt;
  logic                  w_sel_wr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [DATA_WIDTH-1:0] w_sel_wmask;

  logic                  r_rdata_vld_p1;
  logic                  r_rdata_src_p1;

  assign w_run = (r_state == ST_RUN);
  assign w_gnt = w_grant0 | w_grant1;

  ct_spsram_128x104_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk      (forever_cpuclk),
    .rst_n    (cpurst_b),
    .i_en     (w_run),
    .i_vld0   (bus.p0_req_vld),
    .i_vld1   (bus.p1_req_vld),
    .o_grant0 (w_grant0),
    .o_grant1 (w_grant1)
  );

  // State register; reset always restarts from RST so the sweep begins at entry 0.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: one RST cycle, 128 INIT cycles, then RUN until the next reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RST:  w_state_nxt = ST_INIT;
      ST_INIT: if (r_init_cnt == '1) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RST;
    endcase
  end

  // Sweep address counter; wraps to 0 on the last INIT cycle and rests at 0 otherwise.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_init_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + 1'b1;
    end else begin
      r_init_cnt <= '0;
    end
  end

  // Select the winning requester's fields; port 1 only when it holds the grant.
  always_comb begin
    w_sel_wr    = bus.p0_req_wr;
    w_sel_addr  = bus.p0_req_addr;
    w_sel_wdata = bus.p0_req_wdata;
    w_sel_wmask = bus.p0_req_wmask;
    if (w_grant1) begin
      w_sel_wr    = bus.p1_req_wr;
      w_sel_addr  = bus.p1_req_addr;
      w_sel_wdata = bus.p1_req_wdata;
      w_sel_wmask = bus.p1_req_wmask;
    end
  end

  // Macro pin mux: idle (disabled, address/data parked at 0), init write, or granted access.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    case (r_state)
      ST_INIT: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = r_init_cnt;
        sram_d    = INIT_VAL;
      end
      ST_RUN: begin
        if (w_gnt) begin
          sram_cen  = 1'b0;
          sram_gwen = ~w_sel_wr;
          sram_a    = w_sel_addr;
          sram_d    = w_sel_wdata;
          sram_wen  = w_sel_wr ? ~w_sel_wmask : '1;
        end
      end
      default: ;
    endcase
  end

  // ---- stage p1: read return, aligned with macro Q one cycle after the grant ----
  // Tag the response with its source; writes never produce a response.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_rdata_vld_p1 <= 1'b0;
      r_rdata_src_p1 <= P0;
    end else begin
      r_rdata_vld_p1 <= w_gnt & ~w_sel_wr;
      r_rdata_src_p1 <= w_grant1 ? P1 : P0;
    end
  end

  assign bus.p0_req_rdy = w_grant0;
  assign bus.p1_req_rdy = w_grant1;
  assign bus.rdata_vld  = r_rdata_vld_p1;
  assign bus.rdata_src  = r_rdata_src_p1;
  assign bus.rdata      = sram_q;
  assign init_done      = w_run;

endmodule

// File: tb/tb_ct_spsram_128x104_ctrl.sv
// Scoreboard bench for ct_spsram_128x104_ctrl with a behavioural macro model.
module tb_ct_spsram_128x104_ctrl;

  localparam int AW = 7;
  localparam int DW = 104;

  logic          clk;
  logic          rst_n;
  logic          init_done;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  ct_spsram_128x104_ctrl_if b ();

  ct_spsram_128x104_ctrl #(
    .STARVE_MAX (4)
  ) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .bus            (b),
    .init_done      (init_done),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  // Behavioural single-port macro: masked write, Q valid the cycle after a read.
  logic [DW-1:0] mem [128];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic          src;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  localparam logic [DW-1:0] ALL1 = {DW{1'b1}};

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic src, input int c);
    exp_t e;
    e.d = d; e.src = src; e.cyc = c;
    sb.push_back(e);
  endtask

  // Monitor: every presented read response must match the oldest expectation.
  always @(negedge clk) begin
    if (b.rdata_vld === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected got %0h want none", b.rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_data", b.rdata, e.d);
        chk("rd_src", DW'(b.rdata_src), DW'(e.src));
        chk("rd_latency", DW'(cyc), DW'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_rdy0"},  DW'(b.p0_req_rdy), '0);
    chk({tag, "_rdy1"},  DW'(b.p1_req_rdy), '0);
    chk({tag, "_rvld"},  DW'(b.rdata_vld), '0);
    chk({tag, "_rsrc"},  DW'(b.rdata_src), '0);
    chk({tag, "_done"},  DW'(init_done), '0);
    chk({tag, "_cen"},   DW'(sram_cen), DW'(1));
    chk({tag, "_gwen"},  DW'(sram_gwen), DW'(1));
    chk({tag, "_wen"},   sram_wen, ALL1);
    chk({tag, "_a"},     DW'(sram_a), '0);
    chk({tag, "_d"},     sram_d, '0);
  endtask

  // Called right after reset release; k counts negedges from the RST cycle.
  // A port-0 read of entry 0 is held pending and must be accepted at k==129.
  task automatic sweep(input int last);
    b.p0_req_vld = 1'b1; b.p0_req_wr = 1'b0; b.p0_req_addr = '0;
    b.p0_req_wdata = '0; b.p0_req_wmask = '0;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (k == 129) begin
        chk("run_done", DW'(init_done), DW'(1));
        chk("run_rdy0", DW'(b.p0_req_rdy), DW'(1));
        chk("run_cen",  DW'(sram_cen), '0);
        chk("run_gwen", DW'(sram_gwen), DW'(1));
        if (b.p0_req_rdy === 1'b1) push_exp('0, 1'b0, cyc + 1);
      end else begin
        chk("init_rdy", DW'({b.p0_req_rdy, b.p1_req_rdy}), '0);
        chk("init_done", DW'(init_done), '0);
        chk("init_cen", DW'(sram_cen), (k == 0) ? DW'(1) : '0);
        if (k > 0) begin
          chk("init_a",    DW'(sram_a), DW'(k - 1));
          chk("init_gwen", DW'(sram_gwen), '0);
          chk("init_wen",  sram_wen, '0);
          chk("init_d",    sram_d, '0);
        end
      end
      if (k < last) step();
    end
    if (last == 129) begin
      step();
      b.p0_req_vld = 1'b0;
    end
  endtask

  task automatic req(input bit port, input bit wr, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, input logic [DW-1:0] wm,
                     input logic [DW-1:0] exp_d, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    if (port) begin
      b.p1_req_wr = wr; b.p1_req_addr = addr; b.p1_req_wdata = wd; b.p1_req_wmask = wm;
      b.p1_req_vld = 1'b1;
    end else begin
      b.p0_req_wr = wr; b.p0_req_addr = addr; b.p0_req_wdata = wd; b.p0_req_wmask = wm;
      b.p0_req_vld = 1'b1;
    end
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      if ((port ? b.p1_req_rdy : b.p0_req_rdy) === 1'b1) begin
        acc = 1'b1;
        if (!wr) push_exp(exp_d, port, cyc + 1);
      end else begin
        waited++;
        step();
      end
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL req_timeout got no_rdy want rdy port %0d", port);
    end
    step();
    if (port) b.p1_req_vld = 1'b0;
    else      b.p0_req_vld = 1'b0;
  endtask

  int w0, w1;

  initial begin
    rst_n = 1'b0;
    b.p0_req_vld = 1'b0; b.p0_req_wr = 1'b0; b.p0_req_addr = '0;
    b.p0_req_wdata = '0; b.p0_req_wmask = '0;
    b.p1_req_vld = 1'b0; b.p1_req_wr = 1'b0; b.p1_req_addr = '0;
    b.p1_req_wdata = '0; b.p1_req_wmask = '0;
    repeat (3) step();
    reset_check("rst");

    // Init sweep, then the pending read of entry 0 is served.
    rst_n = 1'b1;
    sweep(129);

    // Write then read back in consecutive cycles.
    req(1'b0, 1'b1, 7'd5, 104'hABC, ALL1, '0, w0);
    req(1'b0, 1'b0, 7'd5, '0, '0, 104'hABC, w0);
    chk("p0_read_wait", DW'(w0), '0);

    // Masked write keeps the bits whose mask is 0.
    req(1'b0, 1'b1, 7'd9, ALL1, ALL1, '0, w0);
    req(1'b0, 1'b1, 7'd9, '0, 104'h0F, '0, w0);
    req(1'b0, 1'b0, 7'd9, '0, '0, ALL1 & ~104'hF, w0);

    // Both ports held valid: p0 x4, p1 x1, repeating.
    b.p0_req_wr = 1'b0; b.p0_req_addr = 7'd5; b.p0_req_vld = 1'b1;
    b.p1_req_wr = 1'b0; b.p1_req_addr = 7'd9; b.p1_req_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("starve_grant", DW'({b.p1_req_rdy, b.p0_req_rdy}), (i % 5 == 4) ? DW'(2'b10) : DW'(2'b01));
      if (i % 5 == 4) push_exp(ALL1 & ~104'hF, 1'b1, cyc + 1);
      else            push_exp(104'hABC, 1'b0, cyc + 1);
      step();
    end
    b.p0_req_vld = 1'b0; b.p1_req_vld = 1'b0;
    step();

    // Port 1 alone is granted immediately.
    req(1'b1, 1'b0, 7'd3, '0, '0, '0, w1);
    chk("p1_alone_wait", DW'(w1), '0);

    // Simultaneous: p0 write wins, p1 read waits one cycle and sees new data.
    fork
      req(1'b0, 1'b1, 7'd3, 104'h55, ALL1, '0, w0);
      req(1'b1, 1'b0, 7'd3, '0, '0, 104'h55, w1);
    join
    chk("coll_p0_wait", DW'(w0), '0);
    chk("coll_p1_wait", DW'(w1), DW'(1));
    step();

    // Reset during a granted RUN read: the response must never appear.
    b.p0_req_wr = 1'b0; b.p0_req_addr = 7'd5; b.p0_req_vld = 1'b1;
    @(negedge clk);
    chk("rr_rdy0", DW'(b.p0_req_rdy), DW'(1));
    rst_n = 1'b0;
    #1;
    reset_check("rr");
    b.p0_req_vld = 1'b0;
    @(negedge clk);
    chk("rr_rvld_lost", DW'(b.rdata_vld), '0);
    step();
    rst_n = 1'b1;
    sweep(61);

    // Reset at init count 60, then a full sweep from entry 0.
    rst_n = 1'b0;
    #1;
    reset_check("ri");
    repeat (2) step();
    rst_n = 1'b1;
    sweep(129);

    // Re-init cleared the earlier contents.
    req(1'b0, 1'b0, 7'd5, '0, '0, '0, w0);
    repeat (3) step();

    chk("sb_empty", DW'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ct_spsram_128x104_ctrl.md
Name: ct_spsram_128x104_ctrl

Overview:
- Access controller for one 128-entry x 104-bit single-port SRAM macro in the L2C.
- After reset it clears every entry with a hardware init sweep.
- It then arbitrates two requesters onto the single port: port 0 is the high-priority pipeline, port 1 is the low-priority refill/maintenance path, with starvation protection for port 1.
- It returns read data one cycle after grant, tagged with the source port.

Parameters:
- ADDR_WIDTH, 7, SRAM address width (128 entries).
- DATA_WIDTH, 104, data and write-mask width.
- STARVE_MAX, 4, consecutive port-1 losses after which port 1 wins once (legal range 1..15).
- INIT_VAL, 104'b0, value written to every entry during the init sweep.

Ports:
- forever_cpuclk  in  1  Single clock.
- cpurst_b  in  1  Reset, asynchronous, active-low.
- p0_req_vld  in  1  Port 0 request valid.
- p0_req_wr  in  1  1 = write, 0 = read.
- p0_req_addr  in  7  Entry address.
- p0_req_wdata  in  104  Write data.
- p0_req_wmask  in  104  Per-bit write enable, active-high.
- p0_req_rdy  out  1  Port 0 accepted this cycle.
- p1_req_vld, p1_req_wr, p1_req_addr, p1_req_wdata, p1_req_wmask, p1_req_rdy: same as port 0, for port 1.
- rdata_vld  out  1  Read data valid.
- rdata_src  out  1  Source port of the returned read (0/1).
- rdata  out  104  Read data, passed through from sram_q.
- init_done  out  1  Init sweep complete; requests can now be accepted.
- sram_a  out  7  Macro A.
- sram_cen  out  1  Macro CEN, active-low.
- sram_gwen  out  1  Macro GWEN, active-low write.
- sram_wen  out  104  Macro WEN, active-low per-bit (= ~wmask).
- sram_d  out  104  Macro D.
- sram_q  in  104  Macro Q, valid the cycle after a read access.

Behaviour:
- FSM states: RST, INIT, RUN. Async reset forces RST.
- RST: lasts exactly one cycle after cpurst_b deasserts, then INIT.
- INIT: 7-bit counter runs 0..127. Each cycle drives sram_cen=0, sram_gwen=0, sram_wen=all-0, sram_a=cnt, sram_d=INIT_VAL. At cnt==127 go to RUN; counter wraps to 0. Sweep takes 128 cycles.
- RUN: init_done=1.
- Reset values: p0_req_rdy=0, p1_req_rdy=0, rdata_vld=0, rdata_src=0, init_done=0, sram_cen=1, sram_gwen=1, sram_wen=all-1, sram_a=0, sram_d=0, counters 0. Requests are ignored (rdy=0) in RST and INIT.
- Arbitration (RUN, combinational, same cycle):
  - Only one valid: that port wins.
  - Both valid: port 0 wins, unless starve_cnt==STARVE_MAX, in which case port 1 wins.
  - rdy is asserted only to the winner. Accept = vld & rdy.
- The winner's fields drive the macro in the same cycle: sram_cen=0, sram_gwen=~wr, sram_a=addr, sram_d=wdata, sram_wen=~wmask (reads drive wen all-1).
- No winner: sram_cen=1, gwen=1, wen all-1; sram_a and sram_d hold 0.
- starve_cnt (4-bit):
  - Increments when p1_req_vld=1 and port 0 wins; saturates at STARVE_MAX.
  - Clears when port 1 is granted or p1_req_vld=0.
- Read return: rdata_vld is registered as (granted & ~wr); rdata_src is registered as the winner ID. rdata=sram_q, qualified only by rdata_vld. Latency is exactly 1 cycle.
- Writes produce no response.
- Back-to-back accesses are allowed every cycle. Write-then-read of the same address in consecutive cycles returns the new data (macro behaviour).
- Requester must hold vld and fields stable until rdy; a request may drop without being granted.
- Reset asserted mid-INIT or mid-RUN: immediate return to reset values. A pending rdata_vld is lost, and the sweep restarts from 0 after release.

Decomposition:
- Shared package l2c_spsram_pkg:
  - ADDR_WIDTH/DATA_WIDTH constants.
  - FSM state encoding: RST=2'b00, INIT=2'b01, RUN=2'b10.
  - Port-ID constants P0=1'b0, P1=1'b1.
- One natural sub-module: ct_spsram_128x104_arb, a two-port fixed-priority arbiter with starvation counter. Its outputs are grant0/grant1, and it owns starve_cnt.
- The top level holds the FSM, init counter, macro mux and read-return register.

Test Plan:
- Reset release, no requests:
  - rdy=0 for cycles 0..128, sram_cen=0 for exactly 128 cycles with a=0..127 and d=0.
  - init_done rises on the cycle after a=127.
- After init, p0 writes addr 5 data 0xABC mask all-1, then p0 reads addr 5: rdata_vld=1 one cycle after the read grant, rdata=0xABC, rdata_src=0.
- Masked write: write all-1 to addr 9, then write 0 with mask=0x0F, then read: rdata = all-1 with low 4 bits 0.
- p0_req_vld and p1_req_vld both held high continuously (STARVE_MAX=4):
  - Grant pattern is p0,p0,p0,p0,p1 repeating.
  - starve_cnt returns to 0 after each p1 grant.
- p1 reads addr 3 alone while p0 idle: granted the same cycle, rdata_src=1. p0 write and p1 read in the same cycle: p0 granted, p1 waits with rdy=0.
- cpurst_b pulsed low at init cnt=60 and again during a RUN read: all outputs return to reset values, rdata_vld stays 0, sweep restarts at a=0.
